// File: rtl/psram_qspi_ctrl.sv
// Quad-SPI PSRAM master: single-beat bus requests to 0xEB/0x38 transactions.
// Optional PSRAM_ALIGN_CHECK_EN rejects misaligned requests with resp_err.
module psram_qspi_ctrl #(
    parameter int DUMMY_CYCLES = 0,
    parameter int CE_GAP       = 2
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [23:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        sck,
    output logic        ce_n,
    output logic [3:0]  dio_out,
    output logic [3:0]  dio_oe,
    input  logic [3:0]  dio_in
);

    localparam int CW = (DUMMY_CYCLES > 8) ? $clog2(DUMMY_CYCLES) : 3;
    localparam int GW = (CE_GAP > 1) ? $clog2(CE_GAP + 1) : 1;
    localparam logic [7:0] CMD_RD = 8'hEB;
    localparam logic [7:0] CMD_WR = 8'h38;
    localparam logic [CW-1:0] DUMMY_LAST =
        CW'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);
    localparam logic [GW-1:0] GAP_LAST = GW'(CE_GAP);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY,
        S_WDATA, S_RDATA, S_GAP, S_RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [GW-1:0] gcnt;
    logic          we;
    logic [23:0]   addr;
    logic [2:0]    last;
    logic [31:0]   wdata;
    logic [31:0]   rbuf;

    state_t        nx_state;
    logic [CW-1:0] nx_cnt;
    logic [3:0]    nx_out;
    logic [3:0]    nx_oe;
    logic          cnt_last;
    logic [7:0]    cmd;
    logic [4:0]    wr_off;
    logic [4:0]    rd_off;
    logic [23:0]   al_addr;
    logic          misalign;
    logic          first_bit;

    assign al_addr = {req_addr[23:2],
                      req_addr[1] & ~req_size[1],
                      req_addr[0] & (req_size == 2'd0)};

`ifdef PSRAM_ALIGN_CHECK_EN
    assign misalign = ((req_size == 2'd1) & req_addr[0])
                    | (req_size[1] & (|req_addr[1:0]));
`else
    assign misalign = 1'b0;
`endif

    assign first_bit = req_we ? CMD_WR[7] : CMD_RD[7];
    assign cmd       = we ? CMD_WR : CMD_RD;
    assign rd_off    = {cnt[2:1], ~cnt[0], 2'b00};

    // Next-period decode, used at the edge that ends a high phase
    always_comb begin
        case (state)
            S_CMD:   cnt_last = (cnt == CW'(7));
            S_ADDR:  cnt_last = (cnt == CW'(5));
            S_DUMMY: cnt_last = (cnt == DUMMY_LAST);
            default: cnt_last = (cnt == CW'(last));
        endcase
        nx_state = state;
        nx_cnt   = cnt + CW'(1);
        if (cnt_last) begin
            nx_cnt = '0;
            case (state)
                S_CMD:   nx_state = S_ADDR;
                S_ADDR:  nx_state = we ? S_WDATA :
                             ((DUMMY_CYCLES > 0) ? S_DUMMY : S_RDATA);
                S_DUMMY: nx_state = S_RDATA;
                default: nx_state = S_GAP;
            endcase
        end
        wr_off = {nx_cnt[2:1], ~nx_cnt[0], 2'b00};
        nx_out = 4'h0;
        nx_oe  = 4'h0;
        case (nx_state)
            S_CMD: begin
                nx_out = {3'b000, cmd[3'd7 - nx_cnt[2:0]]};
                nx_oe  = 4'b0001;
            end
            S_ADDR: begin
                nx_out = 4'(addr >> (5'd20 - {nx_cnt[2:0], 2'b00}));
                nx_oe  = 4'b1111;
            end
            S_WDATA: begin
                nx_out = 4'(wdata >> wr_off);
                nx_oe  = 4'b1111;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            gcnt       <= '0;
            we         <= 1'b0;
            addr       <= '0;
            last       <= '0;
            wdata      <= '0;
            rbuf       <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            sck        <= 1'b0;
            ce_n       <= 1'b1;
            dio_out    <= 4'h0;
            dio_oe     <= 4'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        we        <= req_we;
                        wdata     <= req_wdata;
                        rbuf      <= '0;
                        case (req_size)
                            2'd0:    last <= 3'd1;
                            2'd1:    last <= 3'd3;
                            default: last <= 3'd7;
                        endcase
                        if (misalign) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            addr    <= al_addr;
                            state   <= S_CMD;
                            cnt     <= '0;
                            ce_n    <= 1'b0;
                            sck     <= 1'b0;
                            dio_out <= {3'b000, first_bit};
                            dio_oe  <= 4'b0001;
                        end
                    end
                end
                S_CMD, S_ADDR, S_DUMMY, S_WDATA, S_RDATA: begin
                    if (!sck) begin
                        sck <= 1'b1;
                        if (state == S_RDATA)
                            rbuf[rd_off +: 4] <= dio_in;
                    end else begin
                        sck     <= 1'b0;
                        state   <= nx_state;
                        cnt     <= nx_cnt;
                        dio_out <= nx_out;
                        dio_oe  <= nx_oe;
                        if (nx_state == S_GAP) begin
                            ce_n <= 1'b1;
                            gcnt <= '0;
                        end
                    end
                end
                S_GAP: begin
                    if (gcnt == GAP_LAST) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= rbuf;
                        resp_err   <= 1'b0;
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psram_qspi_ctrl.sv
// Directed bench for psram_qspi_ctrl against a small quad-SPI PSRAM model.
// Covers command/address/data framing, latency, back-to-back and reset abort.
module tb_psram_qspi_ctrl;

    localparam int DUMMY = 0;
    localparam int GAP   = 2;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [23:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        sck;
    logic        ce_n;
    logic [3:0]  dio_out;
    logic [3:0]  dio_oe;
    logic [3:0]  dio_in = 4'h0;
    wire  [3:0]  dio_bus;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    psram_qspi_ctrl #(.DUMMY_CYCLES(DUMMY), .CE_GAP(GAP)) dut (
        .clock(clock), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .sck(sck), .ce_n(ce_n),
        .dio_out(dio_out), .dio_oe(dio_oe), .dio_in(dio_in)
    );

    for (genvar g = 0; g < 4; g++) begin : g_pad
        assign dio_bus[g] = dio_oe[g] ? dio_out[g] : 1'bz;
    end

    // PSRAM model: samples on sck rise, drives read nibbles on sck fall
    logic [7:0]  mem [0:1023];
    logic [7:0]  m_cmd;
    logic [23:0] m_addr;
    logic [3:0]  m_hi;
    logic [7:0]  m_byte;
    int          m_rises;
    int          m_oe_err = 0;
    int          wd;
    int          rd;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    end

    always @(negedge ce_n) begin
        m_cmd   = 8'h00;
        m_addr  = 24'h0;
        m_rises = 0;
    end

    always @(posedge sck) begin
        if (!ce_n) begin
            if (m_rises < 8) begin
                m_cmd = {m_cmd[6:0], dio_bus[0]};
                if (dio_oe !== 4'b0001) m_oe_err++;
            end else if (m_rises < 14) begin
                m_addr = {m_addr[19:0], dio_bus};
                if (dio_oe !== 4'b1111) m_oe_err++;
            end else if (m_cmd == 8'h38) begin
                wd = m_rises - 14;
                if (dio_oe !== 4'b1111) m_oe_err++;
                if (wd % 2 == 0) m_hi = dio_bus;
                else mem[m_addr[9:0] + 10'(wd / 2)] = {m_hi, dio_bus};
            end else begin
                if (dio_oe !== 4'b0000) m_oe_err++;
            end
            m_rises++;
        end
    end

    always @(negedge sck) begin
        if (!ce_n && m_cmd == 8'hEB && m_rises >= 14 + DUMMY) begin
            rd     = m_rises - 14 - DUMMY;
            m_byte = mem[m_addr[9:0] + 10'(rd / 2)];
            dio_in = (rd % 2 == 0) ? m_byte[7:4] : m_byte[3:0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic we, input logic [23:0] a,
                             input logic [1:0] sz, input logic [31:0] wdv);
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_size  = sz;
        req_wdata = wdv;
        for (int i = 0; i < 200 && !req_ready; i++) @(negedge clock);
        chk("req_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output logic [31:0] rdv, output logic errv,
                             output int lat, output int celow);
        lat   = 0;
        celow = 0;
        for (int i = 0; i < 300; i++) begin
            if (ce_n === 1'b0) celow++;
            if (resp_valid === 1'b1) break;
            @(negedge clock);
            lat++;
        end
        chk("resp_seen", {31'b0, resp_valid}, 32'd1);
        rdv  = resp_rdata;
        errv = resp_err;
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    task automatic do_txn(input logic we, input logic [23:0] a,
                          input logic [1:0] sz, input logic [31:0] wdv,
                          output logic [31:0] rdv, output logic errv,
                          output int lat, output int celow);
        start_req(we, a, sz, wdv);
        wait_resp(rdv, errv, lat, celow);
    endtask

    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          celow;
    int          busy_rdy;
    int          gap_hi;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_ce_n", {31'b0, ce_n}, 32'd1);
        chk("rst_sck", {31'b0, sck}, 32'd0);
        chk("rst_dio", {24'b0, dio_oe, dio_out}, 32'd0);
        chk("rst_hs", {30'b0, req_ready, resp_valid}, 32'd0);
        chk("rst_resp", resp_rdata | {31'b0, resp_err}, 32'd0);
        @(negedge clock);
        rst_n = 1'b1;

        // resp_ready in IDLE must not produce anything
        resp_ready = 1'b1;
        repeat (4) @(negedge clock);
        chk("idle_resp_ready", {31'b0, resp_valid}, 32'd0);
        resp_ready = 1'b0;

        do_txn(1'b1, 24'h000100, 2'd2, 32'hDEADBEEF, rdata, err, lat, celow);
        chk("w4_cmd", {24'b0, m_cmd}, 32'h38);
        chk("w4_addr", {8'b0, m_addr}, 32'h000100);
        chk("w4_mem", {mem[259], mem[258], mem[257], mem[256]}, 32'hDEADBEEF);
        chk("w4_lat", lat, 47);
        chk("w4_celow", celow, 44);
        chk("w4_err", {31'b0, err}, 32'd0);
        chk("w4_rdata", rdata, 32'd0);

        do_txn(1'b0, 24'h000100, 2'd2, 32'h0, rdata, err, lat, celow);
        chk("r4_cmd", {24'b0, m_cmd}, 32'hEB);
        chk("r4_rdata", rdata, 32'hDEADBEEF);
        chk("r4_lat", lat, 47);
        chk("r4_oe", m_oe_err, 0);

        do_txn(1'b1, 24'h000102, 2'd0, 32'h0000005A, rdata, err, lat, celow);
        chk("w1_lat", lat, 35);
        chk("w1_celow", celow, 32);
        do_txn(1'b0, 24'h000100, 2'd2, 32'h0, rdata, err, lat, celow);
        chk("r4b_rdata", rdata, 32'hDE5ABEEF);
        do_txn(1'b0, 24'h000102, 2'd1, 32'h0, rdata, err, lat, celow);
        chk("r2_rdata", rdata, 32'h0000DE5A);
        chk("r2_lat", lat, 39);

        // back-to-back with resp_ready held high
        resp_ready = 1'b1;
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 24'h000200;
        req_size  = 2'd1;
        req_wdata = 32'h00001234;
        for (int i = 0; i < 200 && !req_ready; i++) @(negedge clock);
        @(posedge clock);
        @(negedge clock);
        req_we    = 1'b0;
        req_wdata = 32'h0;
        busy_rdy  = 0;
        gap_hi    = 0;
        for (int i = 0; i < 300 && resp_valid !== 1'b1; i++) begin
            if (req_ready === 1'b1) busy_rdy++;
            if (ce_n === 1'b1) gap_hi++;
            @(negedge clock);
        end
        for (int i = 0; i < 100 && ce_n === 1'b1; i++) begin
            gap_hi++;
            @(negedge clock);
        end
        req_valid = 1'b0;
        chk("b2b_busy_ready", busy_rdy, 0);
        chk("b2b_gap_ge2", {31'b0, gap_hi >= 2}, 32'd1);
        wait_resp(rdata, err, lat, celow);
        chk("b2b_cmd", {24'b0, m_cmd}, 32'hEB);
        chk("b2b_rdata", rdata, 32'h00001234);

        // reset during the address phase of a write
        start_req(1'b1, 24'h000100, 2'd2, 32'h11223344);
        repeat (20) @(negedge clock);
        rst_n = 1'b0;
        #1;
        chk("abort_ce_n", {31'b0, ce_n}, 32'd1);
        chk("abort_oe", {28'b0, dio_oe}, 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        do_txn(1'b0, 24'h000100, 2'd2, 32'h0, rdata, err, lat, celow);
        chk("abort_rdata", rdata, 32'hDE5ABEEF);

        do_txn(1'b0, 24'h000101, 2'd1, 32'h0, rdata, err, lat, celow);
`ifdef PSRAM_ALIGN_CHECK_EN
        chk("mis_celow", celow, 0);
        chk("mis_err", {31'b0, err}, 32'd1);
        chk("mis_rdata", rdata, 32'd0);
`else
        chk("mis_addr", {8'b0, m_addr}, 32'h000100);
        chk("mis_err", {31'b0, err}, 32'd0);
        chk("mis_rdata", rdata, 32'h0000BEEF);
`endif
        chk("oe_total", m_oe_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psram_qspi_ctrl.md
Name: psram_qspi_ctrl

Overview:
- Bus-side master that converts single-beat memory requests into quad-SPI transactions on the external PSRAM pins.
- Drives sck, ce_n and the tri-stated dio[3:0] of the PSRAM device directly; sits between the SoC bus bridge and the PSRAM chip.
- Reads use command 0xEB and writes use command 0x38.
- Command bits are sent serially on dio[0]; the address and data use all four lines.

Parameters:
- DUMMY_CYCLES, 0: sck cycles inserted between the last address nibble and the first read nibble. dio stays released during these cycles.
- CE_GAP, 2: minimum number of clock cycles ce_n is held high between transactions (minimum 1).

Ports:
- clock  in  1  system clock; sck runs at clock/2.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  24  byte address.
- req_size  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is treated as 4 bytes.
- req_wdata  in  32  write data, little-endian; byte i is bits [8i+7:8i].
- resp_valid  out  1  response valid; held until resp_ready.
- resp_ready  in  1  response consumer ready.
- resp_rdata  out  32  read data, little-endian; unread bytes are 0; 0 for writes.
- resp_err  out  1  error flag (see Optional Feature).
- sck  out  1  PSRAM serial clock.
- ce_n  out  1  PSRAM chip enable, active low.
- dio_out  out  4  value driven onto dio.
- dio_oe  out  4  per-line output enable; the pad ties dio[i] = dio_oe[i] ? dio_out[i] : z.
- dio_in  in  4  sampled dio value.

Behaviour:
- Reset values: sck=0, ce_n=1, dio_oe=0, dio_out=0, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, FSM in IDLE.
- sck timing:
  - Each sck period is 2 clock cycles: a low phase then a high phase.
  - dio_out changes only at the clock edge entering a low phase.
  - dio_in is sampled at the clock edge that raises sck.
- IDLE:
  - req_ready=1. On handshake: latch we, addr, N = 1, 2 or 4 bytes, and wdata.
  - Clear the read buffer, set ce_n=0 and go to CMD.
- CMD: 8 sck periods. Command MSB first on dio[0]; dio_oe=4'b0001.
- ADDR: 6 sck periods. Address nibbles MSB first on dio[3:0]; dio_oe=4'b1111.
- DUMMY: DUMMY_CYCLES sck periods, dio_oe=0. Reads only; skipped when the parameter is 0.
- WDATA: 2N sck periods, dio_oe=4'b1111. Bytes go in ascending address order, high nibble first.
- RDATA:
  - dio_oe=0 from the first low phase after ADDR or DUMMY.
  - Captures 2N nibbles, high nibble first. Byte k goes to resp_rdata[8k+7:8k].
- GAP: ce_n=1, sck=0, dio_oe=0 for CE_GAP cycles, then go to RESP.
- RESP:
  - resp_valid=1 until resp_ready; the handshake returns the FSM to IDLE.
  - req_ready stays 0 until then; there are no overlapping transactions.
- Latency from accept to resp_valid:
  - Write: 2·(14+2N) + CE_GAP + 1 clock cycles (a 4-byte write is 47 cycles with defaults).
  - Read: 2·(14+DUMMY_CYCLES+2N) + CE_GAP + 1 clock cycles.
- Counters: one sck-period counter, reloaded at each phase change and wide enough for 8. The address is never incremented by this block.
- Reset mid-transaction: immediate return to reset values (ce_n=1, dio released); partial data is discarded.
- resp_ready held high while in IDLE has no effect.
- A req_valid arriving while busy is held off by req_ready=0 and is not lost.

Optional Feature:
- Macro: PSRAM_ALIGN_CHECK_EN.
- Defined:
  - A request whose addr is not aligned to N (size 1 with addr[0]≠0, or size 2/3 with addr[1:0]≠0) goes to RESP directly.
  - No ce_n activity; resp_err=1 and resp_rdata=0.
- Not defined: addr low bits are forced to the aligned value before issue, and resp_err is constant 0.

Test Plan:
- Write 4B 0xDEADBEEF to 0x000100: dio[0] carries 0,0,1,1,1,0,0,0; address nibbles 0,0,0,1,0,0; data nibbles E,F,B,E,A,D,D,E. ce_n is low for 44 cycles; resp_valid arrives at cycle 47 with resp_err=0.
- Read 4B at 0x000100 against the PSRAM model after the previous write: command 0xEB; dio_oe is 0 during read nibbles; resp_rdata=0xDEADBEEF.
- Write 1B 0x5A at 0x000102, then read 4B at 0x000100: resp_rdata=0xDE5ABEEF. The 2B read at 0x000102 returns 0x0000DE5A.
- Back-to-back requests with resp_ready=1: ce_n is high for ≥2 cycles between transactions; req_ready=0 while busy; the second request completes correctly.
- Assert rst_n low during ADDR of a write: ce_n=1 and dio_oe=0 immediately. A subsequent read returns the pre-existing data.
- Read 2B at 0x000101:
  - With PSRAM_ALIGN_CHECK_EN: no ce_n pulse; resp_err=1 and resp_rdata=0.
  - Without it: the address issued is 0x000100.
